muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative 32-bit signed multiply / divide unit with HI/LO
//                result registers. Works on operand magnitudes: one
//                shift-add (multiply) or restoring shift-subtract (divide)
//                step per cycle for 32 cycles, then a sign-fix cycle that
//                writes HI/LO.
//
//  Ports
//    clk       in   1   clock, rising edge
//    rst_n     in   1   synchronous active-low reset
//    ALUop     in   5   operation code; only MUL and DIV start an operation
//    start     in   1   request strobe, sampled only while idle
//    a         in  32   multiplicand / dividend (two's complement)
//    b         in  32   multiplier / divisor (two's complement)
//    hi        out 32   product[63:32] or remainder
//    lo        out 32   product[31:0] or quotient
//    busy      out  1   operation in progress (stall request)
//    done      out  1   one-cycle pulse, hi/lo valid
//    div_zero  out  1   one-cycle pulse with done for a divide by zero
//
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ALUop,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    // Operation codes from the ALU decoder.
    localparam logic [4:0] C_ALU_MUL = 5'd16;
    localparam logic [4:0] C_ALU_DIV = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] acc_hi_q;     // partial product high / partial remainder
    logic [31:0] acc_lo_q;     // multiplier bits / dividend -> quotient bits
    logic [31:0] opnd_q;       // |a| for multiply, |b| for divide
    logic        is_div_q;
    logic        neg_quo_q;    // sign of product / quotient
    logic        neg_rem_q;    // sign of remainder
    logic        bzero_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q, dz_q;

    logic        w_accept;
    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_sum;
    logic [31:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem;

    assign w_accept = start && ((ALUop == C_ALU_MUL) || (ALUop == C_ALU_DIV));
    assign w_abs_a  = a[31] ? (~a + 32'd1) : a;
    assign w_abs_b  = b[31] ? (~b + 32'd1) : b;

    // Multiply step: add multiplicand when the current multiplier bit is set,
    // then shift the 65-bit {carry, acc_hi, acc_lo} right by one.
    assign w_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);

    // Divide step: the partial remainder is always below the divisor
    // (<= 2^31), so after shifting in the next dividend bit it still fits in
    // 32 bits. The borrow of the trial subtraction decides the quotient bit.
    assign w_rem_sh = {acc_hi_q[30:0], acc_lo_q[31]};
    assign w_diff   = {1'b0, w_rem_sh} - {1'b0, opnd_q};

    // Sign correction of the magnitude results.
    assign w_prod = neg_quo_q ? (~{acc_hi_q, acc_lo_q} + 64'd1) : {acc_hi_q, acc_lo_q};
    assign w_quo  = neg_quo_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
    assign w_rem  = neg_rem_q ? (~acc_hi_q + 32'd1) : acc_hi_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                busy = 1'b1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 6'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            opnd_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        cnt_q     <= 6'd0;
                        is_div_q  <= (ALUop == C_ALU_DIV);
                        neg_quo_q <= a[31] ^ b[31];
                        neg_rem_q <= a[31];
                        bzero_q   <= (b == 32'd0);
                        acc_hi_q  <= 32'd0;
                        if (ALUop == C_ALU_DIV) begin
                            acc_lo_q <= w_abs_a;
                            opnd_q   <= w_abs_b;
                        end else begin
                            acc_lo_q <= w_abs_b;
                            opnd_q   <= w_abs_a;
                        end
                    end
                end
                S_ITER: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (is_div_q) begin
                        acc_hi_q <= w_diff[32] ? w_rem_sh : w_diff[31:0];
                        acc_lo_q <= {acc_lo_q[30:0], ~w_diff[32]};
                    end else begin
                        acc_hi_q <= w_sum[32:1];
                        acc_lo_q <= {w_sum[0], acc_lo_q[31:1]};
                    end
                end
                S_FIX: begin
                    done_q <= 1'b1;
                    if (is_div_q) begin
                        // Remainder of a divide by zero is the dividend itself,
                        // which the restoring loop already leaves in acc_hi.
                        hi_q <= w_rem;
                        lo_q <= bzero_q ? 32'hFFFF_FFFF : w_quo;
                        dz_q <= bzero_q;
                    end else begin
                        hi_q <= w_prod[63:32];
                        lo_q <= w_prod[31:0];
                    end
                end
                default: begin
                    cnt_q <= 6'd0;
                end
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
`default_nettype wire
